// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the dm/im/dbg requesters with fixed-latency read return.
// Optional build macro ARB_AGING_EN promotes a starved im/dbg request above dm.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic              im_gnt,
  output logic              im_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              stall_fetch,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ID_DM  = 2'd0;
  localparam logic [1:0] ID_IM  = 2'd1;
  localparam logic [1:0] ID_DBG = 2'd2;

  logic       w_dm_gnt, w_im_gnt, w_dbg_gnt, w_any_gnt;
  logic       w_im_prom, w_dbg_prom;
  logic [1:0] w_gnt_id;
  logic       r_tag_vld_p [RD_LAT];
  logic [1:0] r_tag_id_p  [RD_LAT];
  logic       w_tail_vld;
  logic [1:0] w_tail_id;

`ifdef ARB_AGING_EN
  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_im_age, r_dbg_age;

  assign w_im_prom  = im_req  && (r_im_age  == CNT_MAX);
  assign w_dbg_prom = dbg_req && (r_dbg_age == CNT_MAX);

  // Wait counters: count lost cycles, saturate, restart on grant or withdrawn request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_im_age  <= '0;
      r_dbg_age <= '0;
    end else begin
      if (!im_req || w_im_gnt)
        r_im_age <= '0;
      else if (r_im_age != CNT_MAX)
        r_im_age <= r_im_age + 1'b1;
      if (!dbg_req || w_dbg_gnt)
        r_dbg_age <= '0;
      else if (r_dbg_age != CNT_MAX)
        r_dbg_age <= r_dbg_age + 1'b1;
    end
  end
`else
  assign w_im_prom  = 1'b0;
  assign w_dbg_prom = 1'b0;
`endif

  // Grant decision; a promoted requester jumps ahead of dm, im first if both are promoted
  always_comb begin
    w_dm_gnt  = 1'b0;
    w_im_gnt  = 1'b0;
    w_dbg_gnt = 1'b0;
    if (rst) begin
      if (w_im_prom)       w_im_gnt  = 1'b1;
      else if (w_dbg_prom) w_dbg_gnt = 1'b1;
      else if (dm_req)     w_dm_gnt  = 1'b1;
      else if (im_req)     w_im_gnt  = 1'b1;
      else if (dbg_req)    w_dbg_gnt = 1'b1;
    end
  end

  assign w_any_gnt = w_dm_gnt | w_im_gnt | w_dbg_gnt;

  always_comb begin
    w_gnt_id  = ID_DM;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_dm_gnt) begin
      w_gnt_id  = ID_DM;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (w_im_gnt) begin
      w_gnt_id  = ID_IM;
      mem_addr  = im_addr;
    end else if (w_dbg_gnt) begin
      w_gnt_id  = ID_DBG;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign mem_en      = w_any_gnt;
  assign dm_gnt      = w_dm_gnt;
  assign im_gnt      = w_im_gnt;
  assign dbg_gnt     = w_dbg_gnt;
  assign stall_fetch = rst && im_req && !w_im_gnt;

  // Tag pipeline p0..p(RD_LAT-1): only reads are tracked, writes retire at grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_vld_p[i] <= 1'b0;
        r_tag_id_p[i]  <= ID_DM;
      end
    end else begin
      r_tag_vld_p[0] <= w_any_gnt && !mem_we;
      r_tag_id_p[0]  <= w_gnt_id;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld_p[i] <= r_tag_vld_p[i-1];
        r_tag_id_p[i]  <= r_tag_id_p[i-1];
      end
    end
  end

  // Tail stage lines up with the memory's read data
  assign w_tail_vld = r_tag_vld_p[RD_LAT-1];
  assign w_tail_id  = r_tag_id_p[RD_LAT-1];

  assign dm_rvalid  = w_tail_vld && (w_tail_id == ID_DM);
  assign im_rvalid  = w_tail_vld && (w_tail_id == ID_IM);
  assign dbg_rvalid = w_tail_vld && (w_tail_id == ID_DBG);
  assign rdata      = w_tail_vld ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RD_LAT=3) with a behavioural single-port memory.
// Starvation expectations follow the ARB_AGING_EN build macro.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int SL  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dm_req, dm_we, im_req, dbg_req, dbg_we;
  logic [AW-1:0] dm_addr, im_addr, dbg_addr, mem_addr;
  logic [DW-1:0] dm_wdata, dbg_wdata, rdata, mem_wdata, mem_rdata;
  logic          dm_gnt, dm_rvalid, im_gnt, im_rvalid, dbg_gnt, dbg_rvalid;
  logic          stall_fetch, mem_en, mem_we;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .stall_fetch(stall_fetch),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents are C0DE0000 | word index; idle cycles push a marker through the read pipe
  logic [DW-1:0] mem   [256];
  logic [DW-1:0] rpipe [LAT];
  assign mem_rdata = rpipe[LAT-1];

  always @(posedge clk) begin
    if (!rst)
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    else if (mem_en && mem_we)
      mem[mem_addr[9:2]] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'hA5A5_A5A5;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  logic [8:0] ctl;
  assign ctl = {dm_gnt, dm_rvalid, im_gnt, im_rvalid, dbg_gnt, dbg_rvalid,
                stall_fetch, mem_en, mem_we};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    im_req = 1'b0; im_addr = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    // Reset with live requests: everything stays quiet
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234; im_req = 1'b1;
    repeat (4) tick();
    #1;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);

    tick(); rst = 1'b1; idle_in(); #1;
    chk("idle_ctl", 32'(ctl), 32'h0);
    chk("idle_rdata", rdata, 32'h0);

    // Reset in the middle of an im read
    tick(); im_req = 1'b1; im_addr = 32'h0; #1;
    chk("rb_im_gnt", 32'(im_gnt), 32'h1);
    chk("rb_mem_en", 32'(mem_en), 32'h1);
    tick(); im_req = 1'b0; rst = 1'b0; #1;
    chk("rb_rst_ctl", 32'(ctl), 32'h0);
    tick(); rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rb_no_rvalid", 32'(im_rvalid), 32'h0);
      chk("rb_rdata0", rdata, 32'h0);
      tick();
    end

    // dm beats im; im served next cycle; results in grant order
    dm_req = 1'b1; dm_addr = 32'h100; im_req = 1'b1; im_addr = 32'h0; #1;
    chk("c0_dm_gnt", 32'(dm_gnt), 32'h1);
    chk("c0_im_gnt", 32'(im_gnt), 32'h0);
    chk("c0_stall", 32'(stall_fetch), 32'h1);
    chk("c0_maddr", mem_addr, 32'h100);
    tick(); dm_req = 1'b0; #1;
    chk("c1_im_gnt", 32'(im_gnt), 32'h1);
    chk("c1_stall", 32'(stall_fetch), 32'h0);
    chk("c1_maddr", mem_addr, 32'h0);
    tick(); im_req = 1'b0; #1;
    chk("c2_ctl", 32'(ctl), 32'h0);
    tick(); #1;
    chk("c3_dm_rvalid", 32'(dm_rvalid), 32'h1);
    chk("c3_im_rvalid", 32'(im_rvalid), 32'h0);
    chk("c3_rdata", rdata, 32'hC0DE_0040);
    tick(); #1;
    chk("c4_im_rvalid", 32'(im_rvalid), 32'h1);
    chk("c4_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("c4_rdata", rdata, 32'hC0DE_0000);
    tick(); #1;
    chk("c5_rdata", rdata, 32'h0);

    // Write then read-back of the same address
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; #1;
    chk("d0_gnt", 32'(dm_gnt), 32'h1);
    chk("d0_mem_we", 32'(mem_we), 32'h1);
    chk("d0_mwdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); dm_we = 1'b0; #1;
    chk("d1_gnt", 32'(dm_gnt), 32'h1);
    chk("d1_mem_we", 32'(mem_we), 32'h0);
    tick(); idle_in(); tick(); #1;
    chk("d3_no_wr_rvalid", 32'(dm_rvalid), 32'h0);
    tick(); #1;
    chk("d4_dm_rvalid", 32'(dm_rvalid), 32'h1);
    chk("d4_rdata", rdata, 32'hDEAD_BEEF);

    // Back-to-back fetches, dbg granted alongside the first return
    tick(); im_req = 1'b1; im_addr = 32'h0; #1;
    chk("e0_im_gnt", 32'(im_gnt), 32'h1);
    tick(); im_addr = 32'h4; #1;
    chk("e1_im_gnt", 32'(im_gnt), 32'h1);
    tick(); im_addr = 32'h8; #1;
    chk("e2_im_gnt", 32'(im_gnt), 32'h1);
    tick(); im_req = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h4; #1;
    chk("e3_im_rvalid", 32'(im_rvalid), 32'h1);
    chk("e3_rdata", rdata, 32'hC0DE_0000);
    chk("e3_dbg_gnt", 32'(dbg_gnt), 32'h1);
    tick(); dbg_req = 1'b0; #1;
    chk("e4_im_rvalid", 32'(im_rvalid), 32'h1);
    chk("e4_rdata", rdata, 32'hC0DE_0001);
    tick(); #1;
    chk("e5_im_rvalid", 32'(im_rvalid), 32'h1);
    chk("e5_rdata", rdata, 32'hC0DE_0002);
    tick(); #1;
    chk("e6_im_rvalid", 32'(im_rvalid), 32'h0);
    chk("e6_dbg_rvalid", 32'(dbg_rvalid), 32'h1);
    chk("e6_rdata", rdata, 32'hC0DE_0001);

    // dm request withdrawn before the clock edge; im takes the slot
    tick(); im_req = 1'b1; im_addr = 32'h8; dm_req = 1'b1; dm_addr = 32'h300; #1;
    chk("f0_dm_gnt_pre", 32'(dm_gnt), 32'h1);
    dm_req = 1'b0; #1;
    chk("f0_dm_gnt", 32'(dm_gnt), 32'h0);
    chk("f0_im_gnt", 32'(im_gnt), 32'h1);
    chk("f0_maddr", mem_addr, 32'h8);
    tick(); idle_in(); tick(); tick(); #1;
    chk("f3_im_rvalid", 32'(im_rvalid), 32'h1);
    chk("f3_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("f3_rdata", rdata, 32'hC0DE_0002);

    // dbg held against alternating dm/im traffic
    for (int k = 0; k < 100; k++) begin
      tick();
      dm_req = (k % 2 == 0); dm_addr = 32'h0;
      im_req = (k % 2 == 1); im_addr = 32'h4;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
      #1;
`ifdef ARB_AGING_EN
      if (k < SL) begin
        chk("g_dbg_wait", 32'(dbg_gnt), 32'h0);
      end else begin
        chk("g_dbg_promoted", 32'(dbg_gnt), 32'h1);
        chk("g_dm_lost", 32'(dm_gnt), 32'h0);
        break;
      end
`else
      chk("g_dbg_starved", 32'(dbg_gnt), 32'h0);
`endif
    end
    tick(); idle_in();
    repeat (LAT + 1) tick();
    #1;
    chk("g_drain_ctl", 32'(ctl), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
